model_layer_node_unit_accumulator: RTL and testbench
====================================================

# model_layer_node_unit_accumulator

Sequential FP32 accumulator that sits directly downstream of the per-node FP32 multiplier in a model layer node unit. It consumes one weight×activation product per cycle over a valid/ready stream, sums N_INPUTS products onto a preloaded bias, and presents the node's pre-activation (or ReLU) result on a valid/ready output. One instance serves one neuron; the layer controller issues `start` per node evaluation.

## Interface
- `N_INPUTS`, 784, number of products summed per node evaluation (≥1)
- `CNT_W`, 10, product counter width; must satisfy 2^CNT_W > N_INPUTS
- `clk` input 1 — single clock, all state updates on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `start` input 1 — one-cycle pulse; loads `bias`, clears count, enters ACC
- `bias` input 32 — FP32 bias, sampled only on `start`
- `in_valid` input 1 — product on `in_data` is valid
- `in_data` input 32 — FP32 product from the node multiplier
- `in_ready` output 1 — accumulator accepts `in_data` this cycle
- `out_valid` output 1 — `out_data` holds the final node result
- `out_data` output 32 — FP32 node result
- `out_ready` input 1 — consumer accepts `out_data`
- `busy` output 1 — high in ACC or DONE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. `start` → acc←`bias`, cnt←0, go ACC.
- ACC: `in_ready`=1. Transfer = `in_valid`&`in_ready`; on transfer acc←fpadd(acc,`in_data`), cnt←cnt+1. Transfer with cnt==N_INPUTS-1 → DONE. Bubbles (in_valid=0) hold acc and cnt.
- DONE: `in_ready`=0, `out_valid`=1, `out_data` = result of acc (see Configuration). `out_valid`&`out_ready` → IDLE.
- `start` in any state (ACC/DONE included) aborts and restarts: acc←`bias`, cnt←0, ACC; `out_valid` drops next cycle. `start` takes priority over a simultaneous transfer or output handshake.
- `in_valid` while not in ACC is ignored (no transfer).
- fpadd rules (combinational, single cycle, same conventions as the multiplier):
  - exp==0 operand treated as zero (denormals flushed); zero + x = x.
  - exp==8'hff operand treated as ±inf; inf + x = inf (acc's inf wins if both inf).
  - Align smaller-magnitude operand by right shift of its 24-bit significand (hidden 1 restored), keep 3 extra bits (guard, round, sticky), add/subtract by sign, normalise (1-bit right on carry, leading-zero left shift otherwise).
  - Round to nearest, ties away from zero, on guard/round/sticky; renormalise on rounding carry.
  - Result exp ≥255 → {s,8'hff,23'd0}; result exp ≤0 → {s,8'd0,23'd0}; exact cancellation → +0 (32'h0).

## Timing
- Reset values: state IDLE, acc 0, cnt 0, `in_ready` 0, `out_valid` 0, `out_data` 0, `busy` 0.
- `in_ready` high the cycle after `start`; throughput one product/cycle.
- `out_valid` asserts the cycle after the N_INPUTS-th transfer; total latency from `start` = N_INPUTS+1 cycles with no bubbles.
- `out_data` is registered and stable while `out_valid`=1 and `out_ready`=0.
- `start` can be re-issued the same cycle as the output handshake.
- Reset asserted mid-ACC/DONE immediately returns all outputs to reset values; partial sum discarded.

## Configuration
- `NODE_ACC_RELU_EN` defined: `out_data` = 32'h0 when acc sign bit is 1 (negatives and −0 clamp to +0), else acc.
- Not defined: `out_data` = acc unmodified (linear output, e.g. for the final logits layer).

## Test plan
- N_INPUTS=4, bias 3F800000, products 3F800000, 40000000, 3F000000, 3F000000 back-to-back → `out_data` 40A00000 (5.0), `out_valid` on cycle 5 after `start`.
- N_INPUTS=4, bias 0, products 40400000, C0400000, 0, 0 → 00000000; repeat with in_valid bubbles every other cycle → same value, `out_valid` after 4th transfer.
- N_INPUTS=4, bias C1000000, products 3F800000 ×4 → C0800000 without `NODE_ACC_RELU_EN`, 00000000 with it.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`=1, `out_data` stable, `in_ready`=0; single-cycle `out_ready` → IDLE next cycle.
- N_INPUTS=2, bias 7F7FFFFF, products 7F7FFFFF, BF800000 → 7F800000 (overflow saturates, inf persists).
- `start` after 2 of 4 products with new bias 40000000, then 4 products 3F800000 → 40C00000; `rst_n` pulse mid-ACC → all outputs 0, state IDLE.

Source files
------------

// File: rtl/model_layer_node_unit_accumulator.sv
// Purpose: per-neuron FP32 accumulator, bias + N_INPUTS products, optional ReLU (NODE_ACC_RELU_EN).
// Latency: out_valid the cycle after the N_INPUTS-th accepted product (N_INPUTS+1 cycles from start).
// Backpressure: in_ready only in ACC; result held registered in DONE until out_valid & out_ready.
module model_layer_node_unit_accumulator #(
    parameter int N_INPUTS = 784,
    parameter int CNT_W    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    state_t            state, state_nxt;
    logic [31:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       sum;
    logic              xfer;
    logic              last;

    // Single-cycle FP32 add: denormals flush to zero, inf dominates, RNE-away on G/R/S.
    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]        ea, eb, eg, d;
        logic              sg;
        logic [23:0]       mg, ms;
        logic [26:0]       big_x, sml_x, sh, lost, m27;
        logic [27:0]       s28;
        logic [24:0]       mr;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic              found;
        logic [31:0]       res;
        ea  = a[30:23];
        eb  = b[30:23];
        res = 32'h0;
        if (ea == 8'hff) begin
            res = {a[31], 8'hff, 23'd0};
        end else if (eb == 8'hff) begin
            res = {b[31], 8'hff, 23'd0};
        end else if (ea == 8'd0) begin
            res = (eb == 8'd0) ? 32'h0 : b;
        end else if (eb == 8'd0) begin
            res = a;
        end else begin
            // The larger magnitude operand sets sign and exponent
            if (a[30:0] >= b[30:0]) begin
                sg = a[31]; eg = ea; d = ea - eb;
                mg = {1'b1, a[22:0]}; ms = {1'b1, b[22:0]};
            end else begin
                sg = b[31]; eg = eb; d = eb - ea;
                mg = {1'b1, b[22:0]}; ms = {1'b1, a[22:0]};
            end
            big_x = {mg, 3'b000};
            sml_x = {ms, 3'b000};
            if (d > 8'd26) begin
                sh = 27'd1;
            end else begin
                sh    = sml_x >> d;
                lost  = sml_x << (8'd27 - d);
                sh[0] = sh[0] | (|lost);
            end
            if (a[31] == b[31]) s28 = {1'b0, big_x} + {1'b0, sh};
            else                s28 = {1'b0, big_x} - {1'b0, sh};
            if (s28 == 28'd0) begin
                res = 32'h0;
            end else begin
                e = $signed({2'b00, eg});
                if (s28[27]) begin
                    m27    = s28[27:1];
                    m27[0] = m27[0] | s28[0];
                    e      = e + 10'sd1;
                end else begin
                    lz    = 5'd0;
                    found = 1'b0;
                    for (int i = 26; i >= 0; i--) begin
                        if (!found) begin
                            if (s28[i]) found = 1'b1;
                            else        lz    = lz + 5'd1;
                        end
                    end
                    m27 = s28[26:0] << lz;
                    e   = e - $signed({5'd0, lz});
                end
                // Guard bit set means at or above half ulp: round away from zero
                mr = {1'b0, m27[26:3]} + {24'd0, m27[2]};
                if (mr[24]) begin
                    mr = mr >> 1;
                    e  = e + 10'sd1;
                end
                if (e >= 10'sd255)     res = {sg, 8'hff, 23'd0};
                else if (e <= 10'sd0)  res = {sg, 8'd0, 23'd0};
                else                   res = {sg, e[7:0], mr[22:0]};
            end
        end
        return res;
    endfunction

    // Final node result as presented to the consumer
    function automatic logic [31:0] node_result(input logic [31:0] x);
`ifdef NODE_ACC_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    assign sum  = fpadd(acc, in_data);
    assign xfer = in_valid & in_ready;
    assign last = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start overrides everything, including a transfer or output handshake
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (xfer && last) state_nxt = DONE;
                DONE:    if (out_ready)    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Accumulator, product counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= 32'h0;
            cnt      <= '0;
            out_data <= 32'h0;
        end else if (start) begin
            acc <= bias;
            cnt <= '0;
        end else if (xfer) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (last) out_data <= node_result(sum);
        end
    end

endmodule

// File: tb/tb_model_layer_node_unit_accumulator.sv
module tb_model_layer_node_unit_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias = 32'h0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    model_layer_node_unit_accumulator #(.N_INPUTS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0]       bias;
        logic [3:0][31:0]  p;
        logic              bub;
        logic [31:0]       exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    vec_t        vecs[10];
    logic [3:0][31:0] ones;

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef NODE_ACC_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input logic [31:0] b, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3, input logic bub,
                                input logic [31:0] exp);
        vec_t v;
        v.bias = b;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.bub  = bub;
        v.exp  = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed output handshake pops one expected result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output actual=%h expected=none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", out_data, mon_exp);
            end
        end
    end

    task automatic start_node(input logic [31:0] b);
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 32'h0BADF00D;
    endtask

    task automatic feed(input logic [3:0][31:0] p, input logic bub);
        int   k   = 0;
        int   cyc = 0;
        logic x;
        while (k < 4 && cyc < 40) begin
            in_valid = !bub || (cyc % 2 == 1);
            in_data  = p[k];
            x        = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (x) k++;
        end
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        if (k != 4) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout actual=%0d expected=4 transfers", k);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_node(input vec_t v);
        start_node(v.bias);
        exp_q.push_back(v.exp);
        feed(v.p, v.bub);
        chk("out_valid_after_last", {31'd0, out_valid}, 32'd1);
        drain();
        chk("idle_after_handshake", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        ones = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[0] = mk(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 1'b0, 32'h40A00000);
        vecs[1] = mk(32'h00000000, 32'h40400000, 32'hC0400000, 32'h0, 32'h0, 1'b0, 32'h00000000);
        vecs[2] = mk(32'h00000000, 32'h40400000, 32'hC0400000, 32'h0, 32'h0, 1'b1, 32'h00000000);
        vecs[3] = mk(32'hC1000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, relu(32'hC0800000));
        vecs[4] = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 32'hBF800000, 32'h0, 32'h0, 1'b0, 32'h7F800000);
        vecs[5] = mk(32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1, 32'h40C00000);
        vecs[6] = mk(32'h3F800000, 32'h33800000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3F800001);
        vecs[7] = mk(32'h40000000, 32'h00000001, 32'h80000000, 32'h0, 32'h0, 1'b0, 32'h40000000);
        vecs[8] = mk(32'h00000000, 32'hC0000000, 32'h3F800000, 32'h0, 32'h0, 1'b0, relu(32'hBF800000));
        vecs[9] = mk(32'h00800000, 32'h0, 32'h0, 32'h0, 32'h80C00000, 1'b0, relu(32'h80000000));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // in_valid in IDLE must be ignored
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Back-to-back node with exact latency, then held output under backpressure
        start_node(32'h3F800000);
        chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = vecs[0].p[k];
            @(posedge clk); #1;
            if (k == 2) chk("lat_early", {31'd0, out_valid}, 32'd0);
        end
        chk("lat_exact", {31'd0, out_valid}, 32'd1);
        in_data = 32'h3F800000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_data", out_data, 32'h40A00000);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        exp_q.push_back(32'h40A00000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_hs_busy", {31'd0, busy}, 32'd0);
        chk("after_hs_queue", exp_q.size(), 32'd0);
        out_ready = 1'b1;

        // Table of whole-node vectors
        for (int i = 0; i < 10; i++) run_node(vecs[i]);

        // Restart mid-ACC after two products; partial sum discarded
        start_node(32'h3F800000);
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        run_node(mk(32'h40000000, ones[0], ones[1], ones[2], ones[3], 1'b0, 32'h40C00000));

        // Restart while DONE and stalled; out_valid drops the next cycle
        out_ready = 1'b0;
        start_node(32'hC0000000);
        feed(ones, 1'b0);
        chk("abort_done_pre", {31'd0, out_valid}, 32'd1);
        start_node(32'h3F800000);
        chk("abort_done_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_done_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        exp_q.push_back(32'h40A00000);
        feed(vecs[0].p, 1'b0);
        drain();

        // Asynchronous reset mid-ACC
        start_node(32'h3F800000);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, in_ready}, 32'd0);
        run_node(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
